// File: rtl/decode_stage_pkg.sv
// Shared definitions for the RV32I decode/operand-fetch stage: opcodes, funct7 codes,
// the registered ALU bundle and the legality check.
package decode_stage_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] pc;
  } alu_bundle_t;

  // Only the ALU-class encodings the downstream ALU can execute are legal.
  function automatic logic is_legal(input logic [6:0] opcode,
                                    input logic [2:0] funct3,
                                    input logic [6:0] funct7);
    logic ok;
    ok = 1'b0;
    case (opcode)
      OP_R:     ok = (funct7 == F7_BASE) ||
                     ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      OP_I: begin
        if (funct3 == 3'b001)      ok = (funct7 == F7_BASE);
        else if (funct3 == 3'b101) ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        else                       ok = 1'b1;
      end
      OP_LUI:   ok = 1'b1;
      OP_AUIPC: ok = 1'b1;
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Instruction, writeback and ALU-bundle signals of the decode stage.
// master = surrounding pipeline, slave = decode_stage.
interface decode_stage_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [31:0]     in_pc;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [4:0]      out_rd;
  logic            out_we;
  logic [31:0]     out_pc;
  logic            illegal;

  modport master (
    output in_valid, in_instr, in_pc, wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_opcode, out_funct3,
           out_funct7, out_rd, out_we, out_pc, illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, wb_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, out_a, out_b, out_opcode, out_funct3,
           out_funct7, out_rd, out_we, out_pc, illegal
  );
endinterface

// File: rtl/decode_stage_regfile_2r1w.sv
// 32-entry integer register file: two combinational reads, one write, x0 hardwired to zero,
// optional forwarding of the same-cycle write to the read ports.
module regfile_2r1w #(
  parameter int XLEN   = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] mem [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      mem[wa] <= wd;
    end
  end

  function automatic logic [XLEN-1:0] rd_sel(input logic [4:0]      ra,
                                             input logic [XLEN-1:0] stored);
    if (ra == 5'd0)                   return '0;
    if (BYPASS && we && (wa == ra))   return wd;
    return stored;
  endfunction

  assign rd1 = rd_sel(ra1, mem[ra1]);
  assign rd2 = rd_sel(ra2, mem[ra2]);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode/operand-fetch stage: decodes R/I-ALU/LUI/AUIPC, reads the register file
// and registers the ALU bundle behind a valid/ready handshake.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit WB_BYPASS = 1'b1
) (
  input logic          clk,
  input logic          rst,
  decode_stage_if.slave bus
);

  logic [XLEN-1:0]        rs1_data, rs2_data;
  logic [6:0]             opcode;
  logic [2:0]             funct3;
  logic [6:0]             funct7;
  logic [4:0]             rd;
  logic signed [XLEN-1:0] imm_i;
  logic [XLEN-1:0]        imm_u;
  logic                   legal, accept;
  alu_bundle_t            dec, bundle_p1;
  logic                   vld_p1, illegal_p1;

  regfile_2r1w #(.XLEN(XLEN), .BYPASS(WB_BYPASS)) u_regfile (
    .clk (clk),
    .rst (rst),
    .we  (bus.wb_en),
    .wa  (bus.wb_rd),
    .wd  (bus.wb_data),
    .ra1 (bus.in_instr[19:15]),
    .ra2 (bus.in_instr[24:20]),
    .rd1 (rs1_data),
    .rd2 (rs2_data)
  );

  assign opcode = bus.in_instr[6:0];
  assign funct3 = bus.in_instr[14:12];
  assign funct7 = bus.in_instr[31:25];
  assign rd     = bus.in_instr[11:7];
  assign imm_i  = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
  assign imm_u  = {bus.in_instr[31:12], 12'b0};
  assign legal  = is_legal(opcode, funct3, funct7);

  assign bus.in_ready = !vld_p1 || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    dec        = '0;
    dec.opcode = opcode;
    dec.funct3 = funct3;
    dec.rd     = rd;
    dec.we     = (rd != 5'd0);
    dec.pc     = bus.in_pc;
    case (opcode)
      OP_R: begin
        dec.a      = rs1_data;
        dec.b      = rs2_data;
        dec.funct7 = funct7;
      end
      OP_I: begin
        dec.a = rs1_data;
        // Shifts carry shamt unsigned and keep funct7 to select SRL vs SRA.
        if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
          dec.b      = {27'b0, bus.in_instr[24:20]};
          dec.funct7 = funct7;
        end else begin
          dec.b = imm_i;
        end
      end
      OP_LUI:   dec.a = imm_u;
      OP_AUIPC: begin
        dec.a = bus.in_pc;
        dec.b = imm_u;
      end
      default: ;
    endcase
  end

  // Stage p1: registered ALU bundle; illegal accepts consume the slot without a bundle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
      bundle_p1  <= '0;
    end else begin
      illegal_p1 <= accept && !legal;
      if (accept) begin
        vld_p1 <= legal;
        if (legal) bundle_p1 <= dec;
      end else if (bus.out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = vld_p1;
  assign bus.illegal    = illegal_p1;
  assign bus.out_a      = bundle_p1.a;
  assign bus.out_b      = bundle_p1.b;
  assign bus.out_opcode = bundle_p1.opcode;
  assign bus.out_funct3 = bundle_p1.funct3;
  assign bus.out_funct7 = bundle_p1.funct7;
  assign bus.out_rd     = bundle_p1.rd;
  assign bus.out_we     = bundle_p1.we;
  assign bus.out_pc     = bundle_p1.pc;

endmodule
